// File: rtl/ahb_slave_mch_if.sv
// AHB-Lite bus bundle for ahb_slave_mch.
// The master modport is the fabric side, the slave modport is the front end.
// HREADY is the bus-level ready returned to the slave; HREADYOUT is its own
// ready contribution.
interface ahb_slave_mch_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HWRITE, HSIZE, HTRANS, HREADY, HWDATA,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HWRITE, HSIZE, HTRANS, HREADY, HWDATA,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_slave_mch.sv
// ahb_slave_mch: AHB-Lite slave front end.
// Routes bus transfers to N_CH write/read FIFO channel pairs, a user register
// port and a read-only status word.
// Wait states are inserted while the addressed FIFO is full (write) or empty
// (read). Bad size, unmapped region or out-of-range index gives a two-cycle
// ERROR response.
// Optional macro AHB_SLV_TIMEOUT_EN: abandons a transfer with ERROR after
// TIMEOUT wait states. Without it, a stalled transfer waits indefinitely.
module ahb_slave_mch #(
    parameter int N_CH     = 4,
    parameter int NUM_REGS = 16,
    parameter int TIMEOUT  = 1023
) (
    input  logic                 clk,
    input  logic                 reset,
    ahb_slave_mch_if.slave       ahb,
    output logic [N_CH-1:0]      w_fifo_write_enable,
    output logic [31:0]          w_fifo_write_data,
    input  logic [N_CH-1:0]      w_fifo_full,
    output logic [N_CH-1:0]      r_fifo_read_enable,
    input  logic [32*N_CH-1:0]   r_fifo_read_data,
    input  logic [N_CH-1:0]      r_fifo_empty,
    output logic [7:0]           u_addr,
    output logic                 u_write,
    output logic [31:0]          u_write_data,
    input  logic [31:0]          u_read_data
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_DATA = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_ERR1 = 3'd3;
    localparam logic [2:0] S_ERR2 = 3'd4;

    localparam logic [1:0] R_REG  = 2'b00;
    localparam logic [1:0] R_FIFO = 2'b01;
    localparam logic [1:0] R_STAT = 2'b10;

    if (N_CH < 1 || N_CH > 16) begin : g_check_nch
        $error("ahb_slave_mch: N_CH must be in 1..16");
    end
    if (NUM_REGS < 1 || NUM_REGS > 256) begin : g_check_regs
        $error("ahb_slave_mch: NUM_REGS must be in 1..256");
    end
    if (TIMEOUT < 1) begin : g_check_timeout
        $error("ahb_slave_mch: TIMEOUT must be at least 1");
    end

    logic [2:0]      state;
    logic [2:0]      state_next;
    logic [1:0]      region_q;
    logic [7:0]      index_q;
    logic            write_q;

    logic [1:0]      dec_region;
    logic [7:0]      dec_index;
    logic            dec_err;
    logic            accept;
    logic            in_data;
    logic            complete;
    logic            ready_out;

    logic [N_CH-1:0] ch_onehot;
    logic [31:0]     ch_rdata;
    logic            ch_blocked;
    logic [31:0]     status_word;
    logic [1:0]      resp_out;
    logic [31:0]     rdata_out;

`ifdef AHB_SLV_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_next;
    logic [CNT_W-1:0] wait_done;
`endif

    logic unused_bits;
    assign unused_bits = &{1'b0, ahb.HADDR[31:12], ahb.HADDR[1:0], ahb.HTRANS[0]};

    // Address-phase decode: classify the incoming transfer and flag any error.
    always_comb begin
        dec_region = ahb.HADDR[11:10];
        dec_index  = ahb.HADDR[9:2];
        dec_err    = (ahb.HSIZE != 3'b010);
        case (dec_region)
            R_REG:   if ({1'b0, dec_index} >= 9'(NUM_REGS)) dec_err = 1'b1;
            R_FIFO:  if ({1'b0, dec_index} >= 9'(N_CH))     dec_err = 1'b1;
            R_STAT:  if (ahb.HWRITE)                         dec_err = 1'b1;
            default: dec_err = 1'b1;
        endcase
    end

    // Channel selection for the registered transfer, plus the status word.
    always_comb begin
        ch_onehot = '0;
        ch_rdata  = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (index_q == 8'(c)) begin
                ch_onehot[c] = 1'b1;
                ch_rdata     = r_fifo_read_data[32*c +: 32];
            end
        end
        ch_blocked = write_q ? |(w_fifo_full & ch_onehot) : |(r_fifo_empty & ch_onehot);
        status_word = '0;
        status_word[N_CH-1:0]   = w_fifo_full;
        status_word[16 +: N_CH] = r_fifo_empty;
    end

    assign in_data   = (state == S_DATA) || (state == S_WAIT);
    assign complete  = in_data && !((region_q == R_FIFO) && ch_blocked);
    assign ready_out = reset || !((in_data && !complete) || (state == S_ERR1));
    assign accept    = !reset && ready_out && ahb.HSEL && ahb.HREADY && ahb.HTRANS[1];

    // Next-state logic; a new address phase overrides the completion target.
    always_comb begin
        state_next = state;
`ifdef AHB_SLV_TIMEOUT_EN
        wait_cnt_next = '0;
        wait_done     = ((state == S_WAIT) ? wait_cnt : '0) + CNT_W'(1);
`endif
        case (state)
            S_IDLE: state_next = S_IDLE;
            S_DATA, S_WAIT: begin
                if (complete) begin
                    state_next = S_IDLE;
                end else begin
`ifdef AHB_SLV_TIMEOUT_EN
                    if (wait_done >= CNT_W'(TIMEOUT)) begin
                        state_next = S_ERR1;
                    end else begin
                        state_next    = S_WAIT;
                        wait_cnt_next = wait_done;
                    end
`else
                    state_next = S_WAIT;
`endif
                end
            end
            S_ERR1:  state_next = S_ERR2;
            S_ERR2:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (accept) begin
            state_next = dec_err ? S_ERR1 : S_DATA;
        end
    end

    // Data-phase outputs; strobes only fire on the cycle the transfer completes.
    always_comb begin
        w_fifo_write_enable = '0;
        r_fifo_read_enable  = '0;
        u_write             = 1'b0;
        u_addr              = '0;
        rdata_out           = '0;
        resp_out            = 2'b00;
        if (!reset) begin
            case (state)
                S_DATA, S_WAIT: begin
                    if (region_q == R_REG) u_addr = index_q;
                    if (complete) begin
                        case (region_q)
                            R_REG: begin
                                if (write_q) u_write = 1'b1;
                                else         rdata_out = u_read_data;
                            end
                            R_FIFO: begin
                                if (write_q) begin
                                    w_fifo_write_enable = ch_onehot;
                                end else begin
                                    r_fifo_read_enable = ch_onehot;
                                    rdata_out          = ch_rdata;
                                end
                            end
                            R_STAT:  rdata_out = status_word;
                            default: rdata_out = '0;
                        endcase
                    end
                end
                S_ERR1, S_ERR2: resp_out = 2'b01;
                default: resp_out = 2'b00;
            endcase
        end
    end

    assign ahb.HREADYOUT     = ready_out;
    assign ahb.HRESP         = resp_out;
    assign ahb.HRDATA        = rdata_out;
    assign w_fifo_write_data = ahb.HWDATA;
    assign u_write_data      = ahb.HWDATA;

    // State register and address-phase capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            region_q <= '0;
            index_q  <= '0;
            write_q  <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                region_q <= dec_region;
                index_q  <= dec_index;
                write_q  <= ahb.HWRITE;
            end
        end
    end

`ifdef AHB_SLV_TIMEOUT_EN
    // Wait-state counter; zero whenever the slave is not in WAIT.
    always_ff @(posedge clk) begin
        if (reset) wait_cnt <= '0;
        else       wait_cnt <= wait_cnt_next;
    end
`endif

endmodule

// File: tb/tb_ahb_slave_mch.sv
// Testbench for ahb_slave_mch (N_CH=4, NUM_REGS=16, TIMEOUT=8).
// Honours AHB_SLV_TIMEOUT_EN when defined.
module tb_ahb_slave_mch;

    localparam int TO_V = 8;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [3:0]  full;
        logic [3:0]  empty;
        int          release_at;
    } stim_t;

    typedef struct {
        logic [1:0]  resp_first;
        logic [1:0]  resp;
        int          waits;
        logic [31:0] rdata;
        logic [3:0]  wen;
        logic [3:0]  ren;
        int          uwrite;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    typedef struct {
        logic [1:0]  resp_first;
        logic [1:0]  resp;
        int          waits;
        logic [31:0] rdata;
        logic [3:0]  wen;
        logic [3:0]  ren;
        int          uwrite;
        logic [7:0]  uaddr;
        logic [31:0] wdata;
        logic        viol;
        logic        hung;
    } obs_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   wen;
    logic [31:0]  wdata_out;
    logic [3:0]   w_full;
    logic [3:0]   ren;
    logic [127:0] rdata_bus;
    logic [3:0]   r_empty;
    logic [7:0]   u_addr;
    logic         u_write;
    logic [31:0]  u_wdata;
    logic [31:0]  u_rdata;

    logic [31:0]  ureg [256];
    logic [31:0]  model_regs [256];
    logic [31:0]  fifo_word [4];

    int           check_count = 0;
    int           err_count   = 0;

    ahb_slave_mch_if bus ();

    assign bus.HREADY = bus.HREADYOUT;

    ahb_slave_mch #(
        .N_CH(4),
        .NUM_REGS(16),
        .TIMEOUT(TO_V)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ahb(bus),
        .w_fifo_write_enable(wen),
        .w_fifo_write_data(wdata_out),
        .w_fifo_full(w_full),
        .r_fifo_read_enable(ren),
        .r_fifo_read_data(rdata_bus),
        .r_fifo_empty(r_empty),
        .u_addr(u_addr),
        .u_write(u_write),
        .u_write_data(u_wdata),
        .u_read_data(u_rdata)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Show-ahead FIFO heads presented to the slave.
    always_comb begin
        rdata_bus = '0;
        for (int c = 0; c < 4; c++) rdata_bus[32*c +: 32] = fifo_word[c];
    end

    assign u_rdata = ureg[u_addr];

    // User register file, cleared with the system reset.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) ureg[i] <= '0;
        end else if (u_write) begin
            ureg[u_addr] <= u_wdata;
        end
    end

    // Hard stop if something wedges beyond every per-transfer bound.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < 256; i++) model_regs[i] = '0;
    endtask

    task automatic busIdle();
        bus.HSEL   = 1'b0;
        bus.HADDR  = '0;
        bus.HWRITE = 1'b0;
        bus.HSIZE  = 3'b010;
        bus.HTRANS = 2'b00;
    endtask

    // Transaction-level reference: the expected outcome of one transfer.
    task automatic predict(input stim_t s, output exp_t e);
        logic [1:0] region;
        logic [7:0] idx;
        logic       is_err;
        logic       blocked;
        int         stall;
        region = s.addr[11:10];
        idx    = s.addr[9:2];
        e = '{resp_first: 2'b00, resp: 2'b00, waits: 0, rdata: 32'h0, wen: 4'h0, ren: 4'h0, uwrite: 0};
        is_err = (s.size != 3'd2) || (region == 2'd3) || (region == 2'd2 && s.write) ||
                 (region == 2'd0 && idx >= 8'd16) || (region == 2'd1 && idx >= 8'd4);
        if (is_err) begin
            e.resp_first = 2'b01;
            e.resp       = 2'b01;
            e.waits      = 1;
        end else if (region == 2'd0) begin
            if (s.write) begin
                e.uwrite = 1;
                model_regs[idx] = s.wdata;
            end else begin
                e.rdata = model_regs[idx];
            end
        end else if (region == 2'd1) begin
            blocked = s.write ? s.full[idx] : s.empty[idx];
            stall   = blocked ? ((s.release_at < 0) ? 1000 : s.release_at) : 0;
`ifdef AHB_SLV_TIMEOUT_EN
            if (stall >= TO_V) begin
                e.resp  = 2'b01;
                e.waits = TO_V + 1;
                return;
            end
`endif
            e.waits = stall;
            if (s.write) begin
                e.wen = 4'b0001 << idx;
            end else begin
                e.ren   = 4'b0001 << idx;
                e.rdata = fifo_word[idx[1:0]];
            end
        end else begin
            e.rdata = {12'h0, s.empty, 12'h0, s.full};
        end
    endtask

    // Drive one transfer and observe its whole data phase.
    task automatic applyStimulus(input stim_t s, output obs_t o);
        logic done;
        o = '{resp_first: 2'b00, resp: 2'b00, waits: 0, rdata: 32'h0, wen: 4'h0, ren: 4'h0,
              uwrite: 0, uaddr: 8'h0, wdata: 32'h0, viol: 1'b0, hung: 1'b0};
        bus.HSEL   = 1'b1;
        bus.HADDR  = s.addr;
        bus.HWRITE = s.write;
        bus.HSIZE  = s.size;
        bus.HTRANS = 2'b10;
        w_full     = s.full;
        r_empty    = s.empty;
        @(posedge clk); #1;
        busIdle();
        bus.HWDATA = s.wdata;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (s.release_at >= 0 && i >= s.release_at) begin
                w_full  = '0;
                r_empty = '0;
            end
            @(negedge clk);
            if (i == 0) o.resp_first = bus.HRESP;
            o.wen    |= wen;
            o.ren    |= ren;
            o.uwrite += int'(u_write);
            if (|wen) o.wdata = wdata_out;
            if (!bus.HREADYOUT && (|wen || |ren || u_write)) o.viol = 1'b1;
            if ($countones({wen, ren, u_write}) > 1) o.viol = 1'b1;
            if (bus.HREADYOUT) begin
                done    = 1'b1;
                o.resp  = bus.HRESP;
                o.rdata = bus.HRDATA;
                o.uaddr = u_addr;
            end else begin
                o.waits++;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            o.hung  = 1'b1;
            reset   = 1'b1;
            w_full  = '0;
            r_empty = '0;
            @(posedge clk); #1;
            reset = 1'b0;
            clearModel();
        end
    endtask

    task automatic compareObs(input string tag, input stim_t s, input exp_t e, input obs_t o);
        checkOutput({tag, ".completed"}, 32'(o.hung), 32'd0);
        if (!o.hung) begin
            checkOutput({tag, ".resp_first"}, 32'(o.resp_first), 32'(e.resp_first));
            checkOutput({tag, ".resp"},       32'(o.resp),       32'(e.resp));
            checkOutput({tag, ".waits"},      32'(o.waits),      32'(e.waits));
            checkOutput({tag, ".rdata"},      o.rdata,           e.rdata);
            checkOutput({tag, ".wen"},        32'(o.wen),        32'(e.wen));
            checkOutput({tag, ".ren"},        32'(o.ren),        32'(e.ren));
            checkOutput({tag, ".uwrite"},     32'(o.uwrite),     32'(e.uwrite));
            checkOutput({tag, ".protocol"},   32'(o.viol),       32'd0);
            if (e.wen != 4'h0) checkOutput({tag, ".wdata"}, o.wdata, s.wdata);
            if (s.addr[11:10] == 2'd0 && e.resp == 2'b00)
                checkOutput({tag, ".uaddr"}, 32'(o.uaddr), 32'(s.addr[9:2]));
        end
    endtask

    function automatic vec_t mkvec(input logic [31:0] addr, input logic wr, input logic [2:0] sz,
                                   input logic [31:0] wd, input logic [3:0] fu, input logic [3:0] em,
                                   input int rel, input logic [1:0] rf, input logic [1:0] rs,
                                   input int wt, input logic [31:0] rd, input logic [3:0] we,
                                   input logic [3:0] re, input int uw);
        vec_t v;
        v.s = '{addr: addr, write: wr, size: sz, wdata: wd, full: fu, empty: em, release_at: rel};
        v.e = '{resp_first: rf, resp: rs, waits: wt, rdata: rd, wen: we, ren: re, uwrite: uw};
        return v;
    endfunction

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, ".hreadyout"}, 32'(bus.HREADYOUT), 32'd1);
        checkOutput({tag, ".hresp"},     32'(bus.HRESP),     32'd0);
        checkOutput({tag, ".hrdata"},    bus.HRDATA,         32'd0);
        checkOutput({tag, ".strobes"},   32'({wen, ren, u_write}), 32'd0);
        checkOutput({tag, ".u_addr"},    32'(u_addr),        32'd0);
    endtask

    vec_t  vt [15];
    stim_t s;
    exp_t  e;
    obs_t  o;
    int    r;

    initial begin
        reset  = 1'b1;
        w_full = '0;
        r_empty = '0;
        bus.HWDATA = '0;
        busIdle();
        clearModel();
        for (int c = 0; c < 4; c++) fifo_word[c] = 32'hA0A0_0000 + 32'(c);

        // Reset state held for two cycles, then released.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkIdleOutputs("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkIdleOutputs("idle");
        @(posedge clk); #1;

        // Directed vectors with hand-derived expectations.
        vt[0]  = mkvec(32'h004, 1, 3'd2, 32'hDEADBEEF, 4'h0, 4'h0, -1, 0, 0, 0, 32'h0, 4'h0, 4'h0, 1);
        vt[1]  = mkvec(32'h004, 0, 3'd2, 32'h0,        4'h0, 4'h0, -1, 0, 0, 0, 32'hDEADBEEF, 4'h0, 4'h0, 0);
        vt[2]  = mkvec(32'h408, 1, 3'd2, 32'h12345678, 4'h4, 4'h0,  3, 0, 0, 3, 32'h0, 4'h4, 4'h0, 0);
        vt[3]  = mkvec(32'h404, 0, 3'd2, 32'h0,        4'h0, 4'h0,  0, 0, 0, 0, 32'hA0A00001, 4'h0, 4'h2, 0);
        vt[4]  = mkvec(32'h40C, 0, 3'd2, 32'h0,        4'h0, 4'h8,  2, 0, 0, 2, 32'hA0A00003, 4'h0, 4'h8, 0);
        vt[5]  = mkvec(32'h800, 0, 3'd2, 32'h0,        4'h5, 4'h2, -1, 0, 0, 0, 32'h00020005, 4'h0, 4'h0, 0);
        vt[6]  = mkvec(32'hC00, 0, 3'd2, 32'h0,        4'h0, 4'h0, -1, 1, 1, 1, 32'h0, 4'h0, 4'h0, 0);
        vt[7]  = mkvec(32'h000, 1, 3'd0, 32'h77,       4'h0, 4'h0, -1, 1, 1, 1, 32'h0, 4'h0, 4'h0, 0);
        vt[8]  = mkvec(32'h800, 1, 3'd2, 32'h99,       4'h0, 4'h0, -1, 1, 1, 1, 32'h0, 4'h0, 4'h0, 0);
        vt[9]  = mkvec(32'h414, 0, 3'd2, 32'h0,        4'h0, 4'h0, -1, 1, 1, 1, 32'h0, 4'h0, 4'h0, 0);
        vt[10] = mkvec(32'h040, 0, 3'd2, 32'h0,        4'h0, 4'h0, -1, 1, 1, 1, 32'h0, 4'h0, 4'h0, 0);
        vt[11] = mkvec(32'h400, 1, 3'd2, 32'hCAFEF00D, 4'h0, 4'h0, -1, 0, 0, 0, 32'h0, 4'h1, 4'h0, 0);
`ifdef AHB_SLV_TIMEOUT_EN
        vt[12] = mkvec(32'h40C, 0, 3'd2, 32'h0,        4'h0, 4'h8, 100, 0, 1, TO_V + 1, 32'h0, 4'h0, 4'h0, 0);
`else
        vt[12] = mkvec(32'h40C, 0, 3'd2, 32'h0,        4'h0, 4'h8, 100, 0, 0, 100, 32'hA0A00003, 4'h0, 4'h8, 0);
`endif
        vt[13] = mkvec(32'h03C, 1, 3'd2, 32'h000055AA, 4'h0, 4'h0, -1, 0, 0, 0, 32'h0, 4'h0, 4'h0, 1);
        vt[14] = mkvec(32'h03C, 0, 3'd2, 32'h0,        4'h0, 4'h0, -1, 0, 0, 0, 32'h000055AA, 4'h0, 4'h0, 0);

        for (int k = 0; k < 15; k++) begin
            predict(vt[k].s, e);
            applyStimulus(vt[k].s, o);
            compareObs($sformatf("vec%0d", k), vt[k].s, vt[k].e, o);
        end

        // Back-to-back reads of ch0 then ch1 with zero-wait pipelining.
        w_full = '0;
        r_empty = '0;
        bus.HSEL = 1'b1; bus.HADDR = 32'h400; bus.HWRITE = 1'b0; bus.HSIZE = 3'b010; bus.HTRANS = 2'b10;
        @(posedge clk); #1;
        bus.HADDR = 32'h404;
        @(negedge clk);
        checkOutput("b2b.first.ready", 32'(bus.HREADYOUT), 32'd1);
        checkOutput("b2b.first.ren",   32'(ren),           32'h1);
        checkOutput("b2b.first.data",  bus.HRDATA,         32'hA0A00000);
        @(posedge clk); #1;
        busIdle();
        @(negedge clk);
        checkOutput("b2b.second.ready", 32'(bus.HREADYOUT), 32'd1);
        checkOutput("b2b.second.ren",   32'(ren),           32'h2);
        checkOutput("b2b.second.data",  bus.HRDATA,         32'hA0A00001);
        checkOutput("b2b.second.resp",  32'(bus.HRESP),     32'd0);
        @(posedge clk); #1;

        // ERROR response: address ignored in ERR1, accepted in ERR2.
        bus.HSEL = 1'b1; bus.HADDR = 32'hC00; bus.HWRITE = 1'b0; bus.HTRANS = 2'b10;
        @(posedge clk); #1;
        bus.HADDR = 32'h008; bus.HWRITE = 1'b1; bus.HWDATA = 32'h11;
        @(negedge clk);
        checkOutput("err1.ready",   32'(bus.HREADYOUT), 32'd0);
        checkOutput("err1.resp",    32'(bus.HRESP),     32'd1);
        checkOutput("err1.strobes", 32'({wen, ren, u_write}), 32'd0);
        @(posedge clk); #1;
        bus.HADDR = 32'h004; bus.HWRITE = 1'b0;
        @(negedge clk);
        checkOutput("err2.ready",   32'(bus.HREADYOUT), 32'd1);
        checkOutput("err2.resp",    32'(bus.HRESP),     32'd1);
        checkOutput("err2.strobes", 32'({wen, ren, u_write}), 32'd0);
        @(posedge clk); #1;
        busIdle();
        @(negedge clk);
        checkOutput("after_err.ready", 32'(bus.HREADYOUT), 32'd1);
        checkOutput("after_err.resp",  32'(bus.HRESP),     32'd0);
        checkOutput("after_err.data",  bus.HRDATA,         model_regs[1]);
        checkOutput("after_err.write", 32'(u_write),       32'd0);
        @(posedge clk); #1;

        // Reset during a full-FIFO stall drops the write.
        bus.HSEL = 1'b1; bus.HADDR = 32'h408; bus.HWRITE = 1'b1; bus.HTRANS = 2'b10;
        w_full = 4'b0100;
        @(posedge clk); #1;
        busIdle();
        bus.HWDATA = 32'hABCD0123;
        @(negedge clk);
        checkOutput("rst_wait.stalled", 32'(bus.HREADYOUT), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        w_full = '0;
        @(negedge clk);
        checkOutput("rst_wait.in_reset.wen", 32'(wen), 32'd0);
        checkOutput("rst_wait.in_reset.ready", 32'(bus.HREADYOUT), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        clearModel();
        @(negedge clk);
        checkIdleOutputs("rst_wait.after");
        @(posedge clk); #1;

        // Randomised transfers against the reference model.
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            s.addr = $urandom;
            s.addr[1:0] = 2'b00;
            if (r < 4) begin
                s.addr[11:10] = 2'd0;
                s.addr[9:2]   = 8'($urandom_range(0, 17));
            end else if (r < 8) begin
                s.addr[11:10] = 2'd1;
                s.addr[9:2]   = 8'($urandom_range(0, 5));
            end else begin
                s.addr[11:10] = (r == 8) ? 2'd2 : 2'd3;
                s.addr[9:2]   = 8'($urandom_range(0, 3));
            end
            s.write = 1'($urandom_range(0, 1));
            s.size  = ($urandom_range(0, 9) == 0) ? 3'd0 : 3'd2;
            s.wdata = $urandom;
            s.full  = 4'($urandom_range(0, 15));
            s.empty = 4'($urandom_range(0, 15));
            s.release_at = (s.addr[11:10] == 2'd1) ? int'($urandom_range(0, 4)) : -1;
            for (int c = 0; c < 4; c++) fifo_word[c] = $urandom;
            predict(s, e);
            applyStimulus(s, o);
            compareObs($sformatf("rand%0d", n), s, e, o);
        end

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule

// File: doc/ahb_slave_mch.md
Name: ahb_slave_mch

Overview:
Parametrised successor to the single-channel AHB slave front end: AHB-Lite slave that demultiplexes bus transfers onto N_CH independent write-FIFO / read-FIFO channel pairs plus one user register port.
- Adds a status region and wait-state insertion on FIFO full/empty.
- Adds ERROR responses for bad size, unmapped region and out-of-range channel.
- Sits between the Qsys AHB fabric and user logic, instantiated inside the top-level wrapper.

Parameters:
N_CH, 4, number of FIFO channel pairs (1..16)
NUM_REGS, 16, user register words in the register region (1..256)
TIMEOUT, 1023, max wait states before ERROR (used only with AHB_SLV_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all logic rising-edge
reset  in  1  synchronous, active-high reset
HSEL  in  1  slave select
HADDR  in  32  address; only [11:2] decoded
HWRITE  in  1  1=write
HSIZE  in  3  transfer size; only 3'b010 legal
HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
HREADY  in  1  bus ready (previous data phase complete)
HWDATA  in  32  write data (data phase)
HREADYOUT  out  1  slave ready
HRESP  out  2  00 OKAY, 01 ERROR
HRDATA  out  32  read data
w_fifo_write_enable  out  N_CH  one-hot write strobe
w_fifo_write_data  out  32  shared write data (=HWDATA)
w_fifo_full  in  N_CH  per-channel full
r_fifo_read_enable  out  N_CH  one-hot read ack (show-ahead FIFOs)
r_fifo_read_data  in  32*N_CH  channel c at bits [32c+31:32c]
r_fifo_empty  in  N_CH  per-channel empty
u_addr  out  8  register word index
u_write  out  1  register write strobe
u_write_data  out  32  register write data
u_read_data  in  32  register read data, combinational from u_addr

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high.
- Address map (HADDR[11:10]):
  - 00: register region; u_addr = HADDR[9:2]; index >= NUM_REGS -> ERROR.
  - 01: FIFO data; channel = HADDR[9:2]; channel >= N_CH -> ERROR.
  - 10: status, read-only; bits[N_CH-1:0] = w_fifo_full, bits[16+N_CH-1:16] = r_fifo_empty, other bits 0; write -> ERROR.
  - 11: unmapped -> ERROR.
- Address phase accepted when HSEL & HREADY & HTRANS[1]. Registered: addr, write, size, decode result.
- HSIZE != 010 -> ERROR.
- IDLE/BUSY or unselected: OKAY, zero wait, no side effect.
- FSM states:
  - IDLE: no pending data phase.
  - DATA: registered transfer in data phase.
  - WAIT: stalled on FIFO.
  - ERR1, ERR2: two-cycle error response.
- DATA, register: completes same cycle, HREADYOUT=1.
  - Write: u_write=1 for 1 cycle, u_write_data=HWDATA.
  - Read: HRDATA=u_read_data.
  - u_addr holds the registered index during the data phase.
- DATA, FIFO write, !w_fifo_full[c]: w_fifo_write_enable[c]=1 that cycle, HREADYOUT=1.
- DATA, FIFO write, full: HREADYOUT=0, go to WAIT.
- DATA, FIFO read, !r_fifo_empty[c]: HRDATA = channel c data, r_fifo_read_enable[c]=1, HREADYOUT=1.
- DATA, FIFO read, empty: HREADYOUT=0, go to WAIT.
- WAIT: HREADYOUT=0, condition re-evaluated every cycle. The cycle it clears, perform the DATA-state action with HREADYOUT=1. Strobes are never asserted while HREADYOUT=0.
- ERR1: HREADYOUT=0, HRESP=01. No strobes. The bus address phase is ignored (HREADY low).
- ERR2: HREADYOUT=1, HRESP=01. A new address phase may be accepted this cycle.
- Back-to-back: a new address phase accepted on the completing data-phase cycle goes directly to DATA (zero-wait pipelining).
- Outputs in reset and IDLE: HREADYOUT=1, HRESP=00, HRDATA=0, all strobes 0, u_addr=0. Reset mid-WAIT drops the transfer with no strobe.
- At most one strobe bit asserted in any cycle.

Optional Feature:
AHB_SLV_TIMEOUT_EN:
- Defined: a 10-bit-min wait counter increments in WAIT.
  - Reaching TIMEOUT wait states -> ERR1/ERR2, no strobe.
  - Counter cleared on leaving WAIT.
- Undefined: WAIT holds indefinitely; TIMEOUT unused; no counter logic.

Test Plan:
- Reset 2 cycles -> HREADYOUT=1, HRESP=00, HRDATA=0, all strobes 0.
- Write 0xDEADBEEF to 0x004 (reg 1), then read 0x004 with u_read_data echoing -> u_write pulse 1 cycle, u_addr=1, read OKAY 0 waits, HRDATA=0xDEADBEEF.
- Write 0x12345678 to 0x408 (ch 2) with w_fifo_full[2]=1 for 3 cycles -> 3 wait states, then w_fifo_write_enable=4'b0100 with data 0x12345678 in the same cycle as HREADYOUT=1.
- Back-to-back NONSEQ reads of ch0, ch1, both non-empty -> 2 consecutive zero-wait data phases, r_fifo_read_enable 0001 then 0010, correct data.
- Each of: access 0xC00; HSIZE=000; write 0x800; channel 5 with N_CH=4 -> two-cycle ERROR (HREADYOUT 0 then 1, HRESP=01), no strobes.
- With AHB_SLV_TIMEOUT_EN, TIMEOUT=8, read of empty ch3 held empty -> exactly 8 wait states then ERROR, r_fifo_read_enable never set. Without the macro -> still waiting at cycle 100, then completes OKAY when empty deasserts.
